// File: rtl/agu_pkg.sv
// Shared types for the nested-loop address generator (agu_nd and its level selector).
package agu_pkg;

  localparam int AGU_BWADDR   = 21;
  localparam int AGU_BWLENGTH = 8;
  localparam int AGU_NLOOPS   = 5;

  typedef logic [AGU_BWADDR-1:0]   addr_t;
  typedef logic [AGU_BWLENGTH-1:0] len_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/agu_nd_sel.sv
// Level selector: picks the innermost level whose counter is non-zero (one-hot),
// and flags when every counter has run out.
module agu_nd_sel #(
  parameter int NLOOPS = 5
) (
  input  logic [NLOOPS-1:0] zero_i,
  output logic [NLOOPS-1:0] onehot_o,
  output logic              all_zero_o
);

  // Later (inner) levels overwrite earlier ones, so the innermost non-zero wins.
  always_comb begin
    onehot_o = '0;
    for (int k = 0; k < NLOOPS; k++) begin
      if (!zero_i[k]) begin
        onehot_o    = '0;
        onehot_o[k] = 1'b1;
      end
    end
  end

  assign all_zero_o = &zero_i;

endmodule

// File: rtl/agu_nd.sv
// N-level nested-loop address generator with start/done run control and valid/ready output.
// Build option: define AGU_ND_REPEAT_EN to replay the pattern forever instead of entering DONE.
module agu_nd
  import agu_pkg::*;
#(
  parameter int BWADDR   = AGU_BWADDR,
  parameter int BWLENGTH = AGU_BWLENGTH,
  parameter int NLOOPS   = AGU_NLOOPS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                start,
  input  logic [BWADDR-1:0]   base,
  input  logic [BWLENGTH-1:0] l [NLOOPS],
  input  logic [BWADDR-1:0]   j [NLOOPS],
  output logic [BWADDR-1:0]   addr_out,
  output logic                valid,
  input  logic                ready,
  output logic                last,
  output logic                busy,
  output logic                done,
  output logic [NLOOPS-1:0]   on_j,
  output logic                z_out [NLOOPS]
);

  // Handshake: an address is transferred in any cycle where valid & ready are both
  // high; while ready is low addr_out, last and the loop counters hold.

  state_t              state_q, state_d;
  logic [BWADDR-1:0]   addr_q, addr_d;
  logic                last_q, last_d;
  logic [BWLENGTH-1:0] cnt_q [NLOOPS];
  logic [BWLENGTH-1:0] cnt_d [NLOOPS];
  logic [BWLENGTH-1:0] l_q   [NLOOPS];
  logic [BWLENGTH-1:0] l_d   [NLOOPS];
  logic [BWADDR-1:0]   j_q   [NLOOPS];
  logic [BWADDR-1:0]   j_d   [NLOOPS];
`ifdef AGU_ND_REPEAT_EN
  logic [BWADDR-1:0]   base_q, base_d;
`endif

  logic [NLOOPS-1:0]   cnt_zero;
  logic [NLOOPS-1:0]   sel_onehot;
  logic                all_zero;
  logic                acc;
  logic                below;
  logic                any_nz;

  always_comb begin
    for (int k = 0; k < NLOOPS; k++) cnt_zero[k] = (cnt_q[k] == '0);
  end

  agu_nd_sel #(.NLOOPS(NLOOPS)) u_sel (
    .zero_i     (cnt_zero),
    .onehot_o   (sel_onehot),
    .all_zero_o (all_zero)
  );

  assign valid    = (state_q == RUN);
  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign addr_out = addr_q;
  assign last     = last_q;
  assign acc      = valid & ready;
  assign on_j     = acc ? sel_onehot : '0;

  always_comb begin
    for (int k = 0; k < NLOOPS; k++) z_out[k] = acc & cnt_zero[k];
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    l_d     = l_q;
    j_d     = j_q;
`ifdef AGU_ND_REPEAT_EN
    base_d  = base_q;
`endif
    below   = 1'b0;
    any_nz  = 1'b0;
    last_d  = 1'b0;

    if (clr) begin
      state_d = IDLE;
      addr_d  = '0;
      for (int k = 0; k < NLOOPS; k++) begin
        cnt_d[k] = '0;
        l_d[k]   = '0;
        j_d[k]   = '0;
      end
`ifdef AGU_ND_REPEAT_EN
      base_d  = '0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d = RUN;
            addr_d  = base;
            l_d     = l;
            j_d     = j;
            cnt_d   = l;
`ifdef AGU_ND_REPEAT_EN
            base_d  = base;
`endif
          end
        end
        RUN: begin
          if (acc) begin
            if (all_zero) begin
`ifdef AGU_ND_REPEAT_EN
              cnt_d  = l_q;
              addr_d = base_q;
`else
              state_d = DONE;
`endif
            end else begin
              // Levels inside the jumping one restart; levels outside it hold.
              for (int k = 0; k < NLOOPS; k++) begin
                if (below) begin
                  cnt_d[k] = l_q[k];
                end else if (sel_onehot[k]) begin
                  cnt_d[k] = cnt_q[k] - 1'b1;
                  addr_d   = addr_q + j_q[k];
                  below    = 1'b1;
                end
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // last marks the address whose counters have all run out.
    for (int k = 0; k < NLOOPS; k++) any_nz = any_nz | (cnt_d[k] != '0);
    last_d = (state_d == RUN) && !any_nz;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      last_q  <= 1'b0;
      for (int k = 0; k < NLOOPS; k++) begin
        cnt_q[k] <= '0;
        l_q[k]   <= '0;
        j_q[k]   <= '0;
      end
`ifdef AGU_ND_REPEAT_EN
      base_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      l_q     <= l_d;
      j_q     <= j_d;
`ifdef AGU_ND_REPEAT_EN
      base_q  <= base_d;
`endif
    end
  end

endmodule
